// File: rtl/debounce_fsm.sv
// Switch debouncer: two-flop synchroniser, free-running sample tick,
// and a four-state qualifier that only moves db after STABLE_TICKS ticks.
module debounce_fsm #(
    parameter int TICK_BITS    = 19,
    parameter int STABLE_TICKS = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic sw,
    output logic db,
    output logic pending
);

    localparam int CW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } state_t;

    state_t               state;
    state_t               state_next;
    logic                 s1;
    logic                 sw_s;
    logic [TICK_BITS-1:0] q;
    logic                 m_tick;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_next;

    assign m_tick = &q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1    <= 1'b0;
            sw_s  <= 1'b0;
            q     <= '0;
            cnt   <= '0;
            state <= ZERO;
        end else begin
            s1    <= sw;
            sw_s  <= s1;
            q     <= q + TICK_BITS'(1);
            cnt   <= cnt_next;
            state <= state_next;
        end
    end

    // An input reversal is checked before m_tick so it always wins.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        db         = 1'b0;
        pending    = 1'b0;
        case (state)
            ZERO: begin
                if (sw_s) begin
                    state_next = WAIT1;
                    cnt_next   = '0;
                end
            end
            WAIT1: begin
                pending = 1'b1;
                if (!sw_s) begin
                    state_next = ZERO;
                end else if (m_tick && cnt == CNT_LAST) begin
                    state_next = ONE;
                end else if (m_tick) begin
                    cnt_next = cnt + CW'(1);
                end
            end
            ONE: begin
                db = 1'b1;
                if (!sw_s) begin
                    state_next = WAIT0;
                    cnt_next   = '0;
                end
            end
            WAIT0: begin
                db      = 1'b1;
                pending = 1'b1;
                if (sw_s) begin
                    state_next = ONE;
                end else if (m_tick && cnt == CNT_LAST) begin
                    state_next = ZERO;
                end else if (m_tick) begin
                    cnt_next = cnt + CW'(1);
                end
            end
            default: begin
                state_next = ZERO;
                cnt_next   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_debounce_fsm.sv
// Bench for debounce_fsm: directed scenarios plus random switch activity,
// all checked against a tick-counting reference of the debounce rules.
module tb_debounce_fsm;

    localparam int TB = 3;
    localparam int ST = 3;
    localparam int PERIOD = 1 << TB;

    logic clk = 1'b0;
    logic reset;
    logic sw;
    logic db;
    logic pending;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 0;

    debounce_fsm #(
        .TICK_BITS(TB),
        .STABLE_TICKS(ST)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sw(sw),
        .db(db),
        .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: db follows the synchronised input once that input has
    // disagreed with db across ST sample ticks without interruption.
    logic m_s1, m_ss, m_db, m_pend;
    int   m_q, m_ticks;
    bit   m_tick;

    always @(posedge clk) begin
        if (reset) begin
            m_s1 = 0; m_ss = 0; m_db = 0; m_pend = 0;
            m_q = 0; m_ticks = 0;
        end else begin
            m_tick = (m_q % PERIOD) == PERIOD - 1;
            if (m_ss != m_db) begin
                if (!m_pend) begin
                    m_pend = 1;
                    m_ticks = 0;
                end else if (m_tick) begin
                    m_ticks++;
                    if (m_ticks == ST) begin
                        m_db = m_ss;
                        m_pend = 0;
                    end
                end
            end else begin
                m_pend = 0;
            end
            m_ss = m_s1;
            m_s1 = sw;
            m_q = (m_q + 1) % PERIOD;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("db_vs_model", 32'(db), 32'(m_db));
            chk("pending_vs_model", 32'(pending), 32'(m_pend));
        end
    end

    // Edges counted from the first edge after the stimulus change (edge 0).
    task automatic measure(input logic val, input int off, input string tag);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (db === val || n >= 40) break;
            n++;
        end
        chk({tag, "_reached"}, 32'(db), 32'(val));
        if (n + off < 19 || n + off > 26)
            $display("latency %s = %0d", tag, n + off);
        chk({tag, "_latency_ok"}, 32'(n + off >= 19 && n + off <= 26), 32'd1);
    endtask

    initial begin
        int flag;
        reset = 1'b1;
        sw = 1'b1;
        repeat (3) @(negedge clk);
        cmp_en = 1;
        chk("reset_db", 32'(db), 32'd0);
        chk("reset_pending", 32'(pending), 32'd0);
        chk("reset_q", 32'(dut.q), 32'd0);

        // power-up with switch already closed
        reset = 1'b0;
        measure(1'b1, 0, "rise_after_reset");

        // release from ONE
        sw = 1'b0;
        measure(1'b0, 0, "release");

        // clean press from ZERO
        sw = 1'b1;
        repeat (3) @(negedge clk);
        chk("press_pending_at2", 32'(pending), 32'd1);
        measure(1'b1, 3, "press");
        repeat (10) @(negedge clk);
        chk("press_hold_db", 32'(db), 32'd1);
        chk("press_hold_pending", 32'(pending), 32'd0);

        // short drop in WAIT0 must not reach db
        flag = 0;
        sw = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (db !== 1'b1) flag = 1;
        end
        sw = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (db !== 1'b1) flag = 1;
        end
        chk("glitch_db_held", 32'(flag), 32'd0);
        chk("glitch_back_to_one", 32'(pending), 32'd0);
        sw = 1'b0;
        measure(1'b0, 0, "release_after_glitch");

        // bounce from ZERO: toggles every 5 cycles never qualify
        flag = 0;
        for (int i = 0; i < 16; i++) begin
            sw = (i % 2 == 0);
            repeat (5) begin
                @(negedge clk);
                if (db !== 1'b0) flag = 1;
            end
        end
        sw = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (db !== 1'b0) flag = 1;
        end
        chk("bounce_db_low", 32'(flag), 32'd0);
        chk("bounce_pending_end", 32'(pending), 32'd0);

        // reset partway through WAIT1
        sw = 1'b1;
        repeat (10) @(negedge clk);
        chk("midwait_pending", 32'(pending), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_db", 32'(db), 32'd0);
        chk("midreset_pending", 32'(pending), 32'd0);
        reset = 1'b0;
        measure(1'b1, 0, "rise_after_midreset");

        // random activity with occasional resets
        repeat (200) begin
            sw = 1'($urandom_range(0, 1));
            reset = ($urandom_range(0, 40) == 0);
            repeat ($urandom_range(1, 40)) @(negedge clk);
            reset = 1'b0;
        end
        repeat (40) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
